// File: rtl/dmem_arbiter.sv
`default_nettype none
// dmem_arbiter: fixed-priority two-port arbiter for a single-ported byte memory,
// with a starvation guard for port 1, one-cycle read tracking and range checking.
module dmem_arbiter #(
  parameter int MEM_BYTES    = 1024,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_i,
  input  logic        we0_i,
  input  logic [15:0] addr0_i,
  input  logic [15:0] wdata0_i,
  input  logic        req1_i,
  input  logic        we1_i,
  input  logic [15:0] addr1_i,
  input  logic [15:0] wdata1_i,
  output logic        gnt0_o,
  output logic        gnt1_o,
  output logic        rvalid0_o,
  output logic        rvalid1_o,
  output logic [15:0] rdata0_o,
  output logic [15:0] rdata1_o,
  output logic        err0_o,
  output logic        err1_o,
  output logic [15:0] mem_address_o,
  output logic [15:0] mem_write_data_o,
  output logic        mem_MemWrite_o,
  output logic        mem_MemRead_o,
  input  logic [15:0] mem_read_data_i
);

  localparam int              CW        = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]   LIMIT_C   = CW'(STARVE_LIMIT);
  localparam logic [15:0]     LAST_ADDR = 16'(MEM_BYTES - 2);

  logic [CW-1:0] starve_q, starve_d;
  logic          rd_pend_q, rd_pend_d;
  logic          rd_own_q, rd_own_d;
  logic          rd_bad_q, rd_bad_d;
  logic [1:0]    err_q, err_d;

  logic          gnt0, gnt1, any_gnt;
  logic          sel_we, in_range;
  logic [15:0]   sel_addr, sel_wdata;

  // Grants are forced low while reset is asserted, even though they are combinational.
  assign gnt1    = rst_n & req1_i & (~req0_i | (starve_q == LIMIT_C));
  assign gnt0    = rst_n & req0_i & ~gnt1;
  assign any_gnt = gnt0 | gnt1;
  assign gnt0_o  = gnt0;
  assign gnt1_o  = gnt1;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = 16'h0000;
    sel_wdata = 16'h0000;
    if (gnt1) begin
      sel_we    = we1_i;
      sel_addr  = addr1_i;
      sel_wdata = wdata1_i;
    end else if (gnt0) begin
      sel_we    = we0_i;
      sel_addr  = addr0_i;
      sel_wdata = wdata0_i;
    end
  end

  assign in_range         = (sel_addr <= LAST_ADDR);
  assign mem_address_o    = sel_addr;
  assign mem_write_data_o = sel_wdata;
  assign mem_MemWrite_o   = any_gnt & sel_we & in_range;
  assign mem_MemRead_o    = any_gnt & ~sel_we & in_range;

  always_comb begin
    rd_pend_d = any_gnt & ~sel_we;
    rd_own_d  = gnt1;
    rd_bad_d  = ~in_range;
    err_d     = {gnt1 & ~in_range, gnt0 & ~in_range};
    starve_d  = starve_q;
    if (!req1_i || gnt1) begin
      starve_d = '0;
    end else if (starve_q != LIMIT_C) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q  <= '0;
      rd_pend_q <= 1'b0;
      rd_own_q  <= 1'b0;
      rd_bad_q  <= 1'b0;
      err_q     <= 2'b00;
    end else begin
      starve_q  <= starve_d;
      rd_pend_q <= rd_pend_d;
      rd_own_q  <= rd_own_d;
      rd_bad_q  <= rd_bad_d;
      err_q     <= err_d;
    end
  end

  // Out-of-range reads complete with zero data; memory was never strobed.
  assign rvalid0_o = rd_pend_q & ~rd_own_q;
  assign rvalid1_o = rd_pend_q & rd_own_q;
  assign rdata0_o  = (rvalid0_o && !rd_bad_q) ? mem_read_data_i : 16'h0000;
  assign rdata1_o  = (rvalid1_o && !rd_bad_q) ? mem_read_data_i : 16'h0000;
  assign err0_o    = err_q[0];
  assign err1_o    = err_q[1];

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// tb_dmem_arbiter: directed scenarios plus randomized two-port traffic checked
// against a byte-array reference memory and a wait-count arbitration model.
module tb_dmem_arbiter;

  localparam int LIMIT = 4;
  localparam int BYTES = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [15:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [15:0] rdata0, rdata1, mem_address, mem_write_data;
  logic        mem_MemWrite, mem_MemRead;
  logic [15:0] mem_read_data = 16'h0000;

  int checks = 0;
  int failures = 0;

  bit [7:0] mem_arr [0:BYTES-1];
  bit [7:0] ref_mem [0:BYTES-1];

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_BYTES(BYTES), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0),
    .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1),
    .gnt0_o(gnt0), .gnt1_o(gnt1),
    .rvalid0_o(rvalid0), .rvalid1_o(rvalid1),
    .rdata0_o(rdata0), .rdata1_o(rdata1),
    .err0_o(err0), .err1_o(err1),
    .mem_address_o(mem_address), .mem_write_data_o(mem_write_data),
    .mem_MemWrite_o(mem_MemWrite), .mem_MemRead_o(mem_MemRead),
    .mem_read_data_i(mem_read_data)
  );

  // Synchronous single-ported big-endian memory behind the arbiter.
  always @(posedge clk) begin
    if (mem_MemWrite) begin
      mem_arr[int'(mem_address)]     <= mem_write_data[15:8];
      mem_arr[int'(mem_address) + 1] <= mem_write_data[7:0];
    end
    if (mem_MemRead)
      mem_read_data <= {mem_arr[int'(mem_address)], mem_arr[int'(mem_address) + 1]};
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; req0 = 1; req1 = 1;
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
      failures++; $display("FAIL reset_gnt got=%b%b want=00", gnt0, gnt1);
    end
    checks++;
    if ({mem_MemRead, mem_MemWrite, rvalid0, rvalid1, err0, err1} !== 6'b0 ||
        rdata0 !== 16'h0 || rdata1 !== 16'h0) begin
      failures++; $display("FAIL reset_outputs got=%b rd0=%h rd1=%h want=0",
        {mem_MemRead, mem_MemWrite, rvalid0, rvalid1, err0, err1}, rdata0, rdata1);
    end
    idle();
    next_cycle();
    rst_n = 1;
    next_cycle();
  endtask

  task automatic test_write_read();
    req0 = 1; we0 = 1; addr0 = 16'h0010; wdata0 = 16'hBEEF;
    @(negedge clk);
    checks++;
    if (gnt0 !== 1 || gnt1 !== 0 || mem_MemWrite !== 1 || mem_MemRead !== 0 ||
        mem_address !== 16'h0010 || mem_write_data !== 16'hBEEF) begin
      failures++; $display("FAIL wr_grant got gnt=%b%b wr=%b rd=%b a=%h d=%h want 10 1 0 0010 beef",
        gnt0, gnt1, mem_MemWrite, mem_MemRead, mem_address, mem_write_data);
    end
    next_cycle();
    we0 = 0;
    @(negedge clk);
    checks++;
    if (gnt0 !== 1 || mem_MemRead !== 1 || mem_MemWrite !== 0 || rvalid0 !== 0) begin
      failures++; $display("FAIL rd_grant got gnt0=%b rd=%b wr=%b rv0=%b want 1 1 0 0",
        gnt0, mem_MemRead, mem_MemWrite, rvalid0);
    end
    next_cycle();
    idle();
    @(negedge clk);
    checks++;
    if (rvalid0 !== 1 || rdata0 !== 16'hBEEF || rvalid1 !== 0 || rdata1 !== 16'h0) begin
      failures++; $display("FAIL rd_data got rv0=%b rd0=%h rv1=%b rd1=%h want 1 beef 0 0000",
        rvalid0, rdata0, rvalid1, rdata1);
    end
    next_cycle();
  endtask

  task automatic test_starvation();
    req0 = 1; we0 = 0; addr0 = 16'h0000;
    req1 = 1; we1 = 0; addr1 = 16'h0002;
    for (int c = 1; c <= LIMIT + 2; c++) begin
      @(negedge clk);
      checks++;
      if (c == LIMIT + 1) begin
        if (gnt1 !== 1 || gnt0 !== 0) begin
          failures++; $display("FAIL starve_win cycle=%0d got=%b%b want=01", c, gnt0, gnt1);
        end
      end else if (gnt0 !== 1 || gnt1 !== 0) begin
        failures++; $display("FAIL starve_deny cycle=%0d got=%b%b want=10", c, gnt0, gnt1);
      end
      next_cycle();
    end
    idle();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_out_of_range();
    req1 = 1; we1 = 0; addr1 = 16'd1023;
    @(negedge clk);
    checks++;
    if (gnt1 !== 1 || mem_MemRead !== 0 || mem_MemWrite !== 0) begin
      failures++; $display("FAIL oob_grant got gnt1=%b rd=%b wr=%b want 1 0 0", gnt1, mem_MemRead, mem_MemWrite);
    end
    next_cycle();
    addr1 = 16'd1022;
    @(negedge clk);
    checks++;
    if (err1 !== 1 || rvalid1 !== 1 || rdata1 !== 16'h0 || err0 !== 0 || rvalid0 !== 0) begin
      failures++; $display("FAIL oob_resp got err1=%b rv1=%b rd1=%h err0=%b rv0=%b want 1 1 0000 0 0",
        err1, rvalid1, rdata1, err0, rvalid0);
    end
    checks++;
    if (gnt1 !== 1 || mem_MemRead !== 1) begin
      failures++; $display("FAIL edge_1022 got gnt1=%b rd=%b want 1 1", gnt1, mem_MemRead);
    end
    next_cycle();
    req1 = 0; req0 = 1; we0 = 1; addr0 = 16'hFFFF; wdata0 = 16'h5A5A;
    @(negedge clk);
    checks++;
    if (err1 !== 0 || rvalid1 !== 1 || gnt0 !== 1 || mem_MemWrite !== 0) begin
      failures++; $display("FAIL ffff_grant got err1=%b rv1=%b gnt0=%b wr=%b want 0 1 1 0",
        err1, rvalid1, gnt0, mem_MemWrite);
    end
    next_cycle();
    idle();
    @(negedge clk);
    checks++;
    if (err0 !== 1 || rvalid0 !== 0) begin
      failures++; $display("FAIL ffff_err got err0=%b rv0=%b want 1 0", err0, rvalid0);
    end
    next_cycle();
  endtask

  task automatic test_hazard();
    req1 = 1; we1 = 1; addr1 = 16'h0020; wdata1 = 16'h1234;
    @(negedge clk);
    checks++;
    if (gnt1 !== 1 || mem_MemWrite !== 1 || rvalid1 !== 0) begin
      failures++; $display("FAIL haz_write got gnt1=%b wr=%b rv1=%b want 1 1 0", gnt1, mem_MemWrite, rvalid1);
    end
    next_cycle();
    req1 = 0; req0 = 1; we0 = 0; addr0 = 16'h0020;
    @(negedge clk);
    checks++;
    if (gnt0 !== 1 || rvalid1 !== 0) begin
      failures++; $display("FAIL haz_read got gnt0=%b rv1=%b want 1 0", gnt0, rvalid1);
    end
    next_cycle();
    idle();
    @(negedge clk);
    checks++;
    if (rvalid0 !== 1 || rdata0 !== 16'h1234 || rvalid1 !== 0) begin
      failures++; $display("FAIL haz_data got rv0=%b rd0=%h rv1=%b want 1 1234 0", rvalid0, rdata0, rvalid1);
    end
    next_cycle();
  endtask

  task automatic test_reset_pending();
    req0 = 1; we0 = 1; addr0 = 16'h0030; wdata0 = 16'hCAFE;
    next_cycle();
    we0 = 0;
    @(negedge clk);
    checks++;
    if (gnt0 !== 1) begin
      failures++; $display("FAIL rp_grant got gnt0=%b want 1", gnt0);
    end
    next_cycle();
    idle();
    rst_n = 0;
    @(negedge clk);
    checks++;
    if ({rvalid0, rvalid1, err0, err1, gnt0, gnt1, mem_MemRead, mem_MemWrite} !== 8'h00 ||
        rdata0 !== 16'h0) begin
      failures++; $display("FAIL rp_in_reset got=%b rd0=%h want 0",
        {rvalid0, rvalid1, err0, err1, gnt0, gnt1, mem_MemRead, mem_MemWrite}, rdata0);
    end
    next_cycle();
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (rvalid0 !== 0) begin
      failures++; $display("FAIL rp_dropped got rv0=%b want 0", rvalid0);
    end
    next_cycle();
    req0 = 1; we0 = 0; addr0 = 16'h0030;
    next_cycle();
    idle();
    @(negedge clk);
    checks++;
    if (rvalid0 !== 1 || rdata0 !== 16'hCAFE) begin
      failures++; $display("FAIL rp_reissue got rv0=%b rd0=%h want 1 cafe", rvalid0, rdata0);
    end
    next_cycle();
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 9))
      0: return 16'd1022;
      1: return 16'd1023;
      2: return 16'hFFFF;
      default: return 16'h0100 + 16'($urandom_range(0, 31));
    endcase
  endfunction

  task automatic test_random();
    bit p0 = 0, p1 = 0;
    logic w0 = 0, w1 = 0;
    logic [15:0] a0 = 0, a1 = 0, d0 = 0, d1 = 0;
    int waited = 0;
    bit eg0, eg1, gw, gin;
    logic [15:0] ga, gd;
    bit ev0 = 0, ev1 = 0, ee0 = 0, ee1 = 0;
    logic [15:0] ed0 = 0, ed1 = 0;
    for (int c = 0; c < 500; c++) begin
      if (p0 && $urandom_range(0, 19) == 0) p0 = 0;
      if (p1 && $urandom_range(0, 19) == 0) p1 = 0;
      if (!p0 && $urandom_range(0, 9) < 6) begin
        p0 = 1; w0 = 1'($urandom_range(0, 1)); a0 = rand_addr(); d0 = 16'($urandom);
      end
      if (!p1 && $urandom_range(0, 9) < 6) begin
        p1 = 1; w1 = 1'($urandom_range(0, 1)); a1 = rand_addr(); d1 = 16'($urandom);
      end
      req0 = p0; we0 = w0; addr0 = a0; wdata0 = d0;
      req1 = p1; we1 = w1; addr1 = a1; wdata1 = d1;
      @(negedge clk);
      eg1 = p1 && (!p0 || waited == LIMIT);
      eg0 = p0 && !eg1;
      checks++;
      if (gnt0 !== eg0 || gnt1 !== eg1) begin
        failures++; $display("FAIL rnd_gnt cycle=%0d got=%b%b want=%b%b", c, gnt0, gnt1, eg0, eg1);
      end
      checks++;
      if ((mem_MemRead && mem_MemWrite) || (gnt0 && gnt1)) begin
        failures++; $display("FAIL rnd_exclusive cycle=%0d rd=%b wr=%b gnt=%b%b want no overlap",
          c, mem_MemRead, mem_MemWrite, gnt0, gnt1);
      end
      checks++;
      if (rvalid0 !== ev0 || rdata0 !== ed0 || err0 !== ee0) begin
        failures++; $display("FAIL rnd_port0 cycle=%0d got rv=%b rd=%h err=%b want %b %h %b",
          c, rvalid0, rdata0, err0, ev0, ed0, ee0);
      end
      checks++;
      if (rvalid1 !== ev1 || rdata1 !== ed1 || err1 !== ee1) begin
        failures++; $display("FAIL rnd_port1 cycle=%0d got rv=%b rd=%h err=%b want %b %h %b",
          c, rvalid1, rdata1, err1, ev1, ed1, ee1);
      end
      {ev0, ev1, ee0, ee1} = 4'b0;
      ed0 = 16'h0; ed1 = 16'h0;
      if (eg0 || eg1) begin
        gw = eg1 ? w1 : w0;
        ga = eg1 ? a1 : a0;
        gd = eg1 ? d1 : d0;
        gin = (int'(ga) <= BYTES - 2);
        if (gw && gin) begin
          ref_mem[int'(ga)] = gd[15:8];
          ref_mem[int'(ga) + 1] = gd[7:0];
        end
        if (!gw) begin
          if (eg1) begin
            ev1 = 1; ed1 = gin ? {ref_mem[int'(ga)], ref_mem[int'(ga) + 1]} : 16'h0;
          end else begin
            ev0 = 1; ed0 = gin ? {ref_mem[int'(ga)], ref_mem[int'(ga) + 1]} : 16'h0;
          end
        end
        if (eg1) ee1 = !gin; else ee0 = !gin;
        if (eg1) p1 = 0; else p0 = 0;
      end
      if (req1 && !eg1) waited = (waited < LIMIT) ? waited + 1 : LIMIT;
      else waited = 0;
      next_cycle();
    end
    idle();
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_starvation();
    test_out_of_range();
    test_hazard();
    test_reset_pending();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
